// File: rtl/wb_trace_monitor.sv
// Retirement trace monitor: captures WB register writes and MEM stores into a
// timestamped FIFO, drains it over valid/ready and halts once the pipeline idles.
module wb_trace_monitor #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CC_W       = 16,
  parameter int unsigned IDLE_LIMIT = 4
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            RegWriteEN_W,
  input  logic [4:0]      RegAddr3_W,
  input  logic [31:0]     RegWriteData_W,
  input  logic            MemWriteEN_M,
  input  logic [31:0]     MemAddr_M,
  input  logic [31:0]     MemWriteData_M,
  input  logic            InstValid_E,
  input  logic            TraceReady,
  output logic            TraceValid,
  output logic            TraceKind,
  output logic [31:0]     TraceAddr,
  output logic [31:0]     TraceData,
  output logic [CC_W-1:0] TraceCycle,
  output logic [CC_W-1:0] CycleCount,
  output logic            Overflow,
  output logic            Halted
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = $clog2(IDLE_LIMIT + 1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

  typedef struct packed {
    logic            kind;
    logic [31:0]     addr;
    logic [31:0]     data;
    logic [CC_W-1:0] cyc;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [AW:0]     cnt_q, cnt_d;
  state_t          state_q;
  logic [IW-1:0]   idle_q;
  logic [CC_W-1:0] cc_q;
  logic            ovf_q, halted_q;

  logic            capture_en, ev_reg, ev_st, pop, drop;
  logic [AW:0]     free;
  logic [1:0]      n_ev, n_push;
  entry_t          reg_ent, st_ent, first_ent, head;

  always_comb begin
    capture_en = (state_q != S_HALT);
    ev_reg     = capture_en && RegWriteEN_W && (RegAddr3_W != '0);
    ev_st      = capture_en && MemWriteEN_M;
    pop        = (cnt_q != '0) && TraceReady;
    // A same-edge pop frees its slot for this edge's pushes.
    free       = DEPTH_C - cnt_q + (AW+1)'(pop);
    n_ev       = {1'b0, ev_reg} + {1'b0, ev_st};
    if (free >= (AW+1)'(n_ev)) n_push = n_ev;
    else                       n_push = free[1:0];
    drop       = (n_push != n_ev);

    reg_ent    = '{kind: 1'b0, addr: {27'b0, RegAddr3_W}, data: RegWriteData_W, cyc: cc_q};
    st_ent     = '{kind: 1'b1, addr: MemAddr_M, data: MemWriteData_M, cyc: cc_q};
    first_ent  = ev_reg ? reg_ent : st_ent;
    cnt_d      = cnt_q + (AW+1)'(n_push) - (AW+1)'(pop);
  end

  always_ff @(posedge CLOCK) begin
    if (n_push != 2'd0) mem_q[wr_ptr_q] <= first_ent;
    if (n_push == 2'd2) mem_q[wr_ptr_q + AW'(1)] <= st_ent;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= S_RUN;
      idle_q   <= '0;
      cc_q     <= '0;
      ovf_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_q + AW'(n_push);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (drop) ovf_q <= 1'b1;
      if (capture_en && (cc_q != '1)) cc_q <= cc_q + CC_W'(1);
      case (state_q)
        S_RUN: begin
          if (InstValid_E) begin
            idle_q <= '0;
          end else begin
            idle_q <= idle_q + IW'(1);
            if (idle_q == IW'(IDLE_LIMIT - 1)) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((cnt_q == '0) && !ev_reg && !ev_st) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    head       = mem_q[rd_ptr_q];
    TraceValid = (cnt_q != '0);
    TraceKind  = TraceValid & head.kind;
    TraceAddr  = TraceValid ? head.addr : '0;
    TraceData  = TraceValid ? head.data : '0;
    TraceCycle = TraceValid ? head.cyc  : '0;
    CycleCount = cc_q;
    Overflow   = ovf_q;
    Halted     = halted_q;
  end

endmodule

// File: tb/tb_wb_trace_monitor.sv
// Randomised and directed bench for wb_trace_monitor, checked every cycle
// against a queue-based model of the trace FIFO and run/drain/halt behaviour.
module tb_wb_trace_monitor;
  localparam int DEPTH = 16, CC_W = 16, IDLE_LIMIT = 4;
  localparam int P_RUN = 0, P_DRAIN = 1, P_HALT = 2;

  logic CLOCK = 1'b0, RESET = 1'b0;
  logic RegWriteEN_W = 1'b0, MemWriteEN_M = 1'b0, InstValid_E = 1'b0, TraceReady = 1'b0;
  logic [4:0]  RegAddr3_W = '0;
  logic [31:0] RegWriteData_W = '0, MemAddr_M = '0, MemWriteData_M = '0;
  logic TraceValid, TraceKind, Overflow, Halted;
  logic [31:0] TraceAddr, TraceData;
  logic [CC_W-1:0] TraceCycle, CycleCount;

  wb_trace_monitor #(.DEPTH(DEPTH), .CC_W(CC_W), .IDLE_LIMIT(IDLE_LIMIT)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .RegWriteEN_W(RegWriteEN_W), .RegAddr3_W(RegAddr3_W), .RegWriteData_W(RegWriteData_W),
    .MemWriteEN_M(MemWriteEN_M), .MemAddr_M(MemAddr_M), .MemWriteData_M(MemWriteData_M),
    .InstValid_E(InstValid_E), .TraceReady(TraceReady),
    .TraceValid(TraceValid), .TraceKind(TraceKind), .TraceAddr(TraceAddr),
    .TraceData(TraceData), .TraceCycle(TraceCycle), .CycleCount(CycleCount),
    .Overflow(Overflow), .Halted(Halted)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    bit            kind;
    bit [31:0]     addr;
    bit [31:0]     data;
    bit [CC_W-1:0] cyc;
  } ent_t;

  ent_t mq[$];
  int   m_phase = P_RUN, m_idle = 0, m_cc = 0;
  bit   m_ovf = 0;

  always @(negedge RESET) begin
    mq.delete();
    m_phase = P_RUN; m_idle = 0; m_cc = 0; m_ovf = 0;
  end

  // Model step on each edge, then one compare of all outputs 1 time unit later.
  always @(posedge CLOCK) begin
    ent_t e;
    int   free, n0;
    bit   er, es;
    if (RESET) begin
      n0   = mq.size();
      er   = (m_phase != P_HALT) && RegWriteEN_W && (RegAddr3_W != 0);
      es   = (m_phase != P_HALT) && MemWriteEN_M;
      free = DEPTH - n0;
      if (n0 > 0 && TraceReady) begin e = mq.pop_front(); free++; end
      if (er) begin
        if (free > 0) begin
          e.kind = 0; e.addr = {27'b0, RegAddr3_W}; e.data = RegWriteData_W; e.cyc = m_cc[CC_W-1:0];
          mq.push_back(e); free--;
        end else m_ovf = 1;
      end
      if (es) begin
        if (free > 0) begin
          e.kind = 1; e.addr = MemAddr_M; e.data = MemWriteData_M; e.cyc = m_cc[CC_W-1:0];
          mq.push_back(e); free--;
        end else m_ovf = 1;
      end
      if (m_phase != P_HALT && m_cc < (1 << CC_W) - 1) m_cc++;
      if (m_phase == P_RUN) begin
        if (InstValid_E) m_idle = 0;
        else begin
          m_idle++;
          if (m_idle == IDLE_LIMIT) m_phase = P_DRAIN;
        end
      end else if (m_phase == P_DRAIN) begin
        if (n0 == 0 && !er && !es) m_phase = P_HALT;
      end
    end
    #1;
    chk("valid", 64'(TraceValid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("kind",  64'(TraceKind),  64'(mq[0].kind));
      chk("addr",  64'(TraceAddr),  64'(mq[0].addr));
      chk("data",  64'(TraceData),  64'(mq[0].data));
      chk("tcyc",  64'(TraceCycle), 64'(mq[0].cyc));
    end
    chk("cycle",   64'(CycleCount), 64'(m_cc));
    chk("ovf",     64'(Overflow),   64'(m_ovf));
    chk("halted",  64'(Halted),     64'(m_phase == P_HALT));
  end

  task automatic drive(input bit rw, input bit [4:0] ra, input bit [31:0] rd,
                       input bit mw, input bit [31:0] ma, input bit [31:0] md,
                       input bit iv, input bit rdy);
    RegWriteEN_W = rw; RegAddr3_W = ra; RegWriteData_W = rd;
    MemWriteEN_M = mw; MemAddr_M = ma; MemWriteData_M = md;
    InstValid_E = iv; TraceReady = rdy;
    @(negedge CLOCK);
  endtask

  task automatic idle_cycles(input int n, input bit iv, input bit rdy);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, iv, rdy);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CC_W-1:0] frozen;
    @(negedge CLOCK); @(negedge CLOCK);
    chk("rst_valid", 64'(TraceValid), 0);
    chk("rst_addr",  64'(TraceAddr), 0);
    chk("rst_data",  64'(TraceData), 0);
    chk("rst_tcyc",  64'(TraceCycle), 0);
    chk("rst_kind",  64'(TraceKind), 0);
    chk("rst_cc",    64'(CycleCount), 0);
    chk("rst_halt",  64'(Halted), 0);
    RESET = 1'b1;

    // Single write at cycle 3, then $0 write ignored while popping.
    idle_cycles(3, 1, 0);
    drive(1, 8, 32'h5, 0, 0, 0, 1, 0);
    chk("t1_valid", 64'(TraceValid), 1);
    chk("t1_addr",  64'(TraceAddr), 8);
    chk("t1_data",  64'(TraceData), 5);
    chk("t1_cyc",   64'(TraceCycle), 3);
    chk("t1_kind",  64'(TraceKind), 0);
    drive(1, 0, 32'h99, 0, 0, 0, 1, 1);
    chk("t1_zero", 64'(TraceValid), 0);

    // Dual event: register entry first, then store.
    drive(1, 2, 32'h11, 1, 32'h40, 32'h22, 1, 0);
    chk("t2_k0", 64'(TraceKind), 0);
    chk("t2_a0", 64'(TraceAddr), 2);
    chk("t2_d0", 64'(TraceData), 32'h11);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    chk("t2_k1", 64'(TraceKind), 1);
    chk("t2_a1", 64'(TraceAddr), 32'h40);
    chk("t2_d1", 64'(TraceData), 32'h22);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    chk("t2_empty", 64'(TraceValid), 0);

    // Overflow: DEPTH-1 entries then a dual event keeps only the register entry.
    for (int i = 0; i < DEPTH - 1; i++) drive(1, 5'(i % 31 + 1), 32'(i), 0, 0, 0, 1, 0);
    chk("t3_noovf", 64'(Overflow), 0);
    drive(1, 9, 32'hAA, 1, 32'h80, 32'hBB, 1, 0);
    chk("t3_ovf", 64'(Overflow), 1);
    idle_cycles(DEPTH, 1, 1);
    chk("t3_drained", 64'(TraceValid), 0);
    chk("t3_sticky",  64'(Overflow), 1);

    // Asynchronous reset with entries queued.
    for (int i = 0; i < 5; i++) drive(1, 5'(i + 1), 32'(i), 0, 0, 0, 1, 0);
    chk("t4_pending", 64'(TraceValid), 1);
    #2 RESET = 1'b0;
    #1;
    chk("t4_valid", 64'(TraceValid), 0);
    chk("t4_ovf",   64'(Overflow), 0);
    chk("t4_halt",  64'(Halted), 0);
    chk("t4_cc",    64'(CycleCount), 0);
    @(negedge CLOCK);
    RESET = 1'b1;
    drive(1, 3, 32'h33, 0, 0, 0, 1, 0);
    chk("t4_cyc0", 64'(TraceCycle), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1);

    // Wrap: 3*DEPTH alternating writes/stores, ready toggling.
    for (int i = 0; i < 6 * DEPTH; i++) begin
      if (i % 2 == 0) begin
        if ((i / 2) % 2 == 0)
          drive(1, 5'($urandom_range(31, 1)), $urandom, 0, 0, 0, 1, 0);
        else
          drive(0, 0, 0, 1, $urandom, $urandom, 1, 0);
      end else drive(0, 0, 0, 0, 0, 0, 1, 1);
    end
    idle_cycles(4, 1, 1);
    chk("t5_empty", 64'(TraceValid), 0);
    chk("t5_noovf", 64'(Overflow), 0);

    // Random traffic, including $0 writes and backpressure.
    for (int i = 0; i < 400; i++)
      drive($urandom_range(1, 0), 5'($urandom_range(31, 0)), $urandom,
            $urandom_range(1, 0), $urandom, $urandom, 1, ($urandom_range(3, 0) != 0));
    idle_cycles(DEPTH + 2, 1, 1);

    // Halt: idle EX, trailing writes still captured, then drain and freeze.
    idle_cycles(10, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 5, 32'h55, 0, 0, 0, 0, 0);
    chk("t6_valid", 64'(TraceValid), 1);
    chk("t6_addr",  64'(TraceAddr), 5);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 6, 32'h66, 0, 0, 0, 0, 0);
    chk("t6_nohalt", 64'(Halted), 0);
    for (int i = 0; i < 40 && !Halted; i++) drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("t6_halted", 64'(Halted), 1);
    frozen = CycleCount;
    for (int i = 0; i < 5; i++) drive(1, 7, 32'h77, 1, 32'h10, 32'h20, 1, 1);
    chk("t6_frozen", 64'(CycleCount), 64'(frozen));
    chk("t6_ignored", 64'(TraceValid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
